// File: rtl/ctx_pkg.sv
// Shared types and constants for the register-file context save/restore engine.
// Build option: CTX_SKIP_R0_EN (see regfile_ctx_engine.sv).
package ctx_pkg;

    // Default number of register-file entries (5-bit register address).
    localparam int CTX_NUM_REGS = 32;

    // Legacy-compatible state encodings; the enum below is built from them.
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SAVE    = 2'd1;
    localparam logic [1:0] S_RESTORE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    typedef enum logic {
        CTX_OP_SAVE    = 1'b0,
        CTX_OP_RESTORE = 1'b1
    } ctx_op_t;

    typedef enum logic [1:0] {
        ST_IDLE    = S_IDLE,
        ST_SAVE    = S_SAVE,
        ST_RESTORE = S_RESTORE,
        ST_DONE    = S_DONE
    } ctx_state_t;

    // One-hot bit for a register index, used to retire a pending register.
    function automatic logic [31:0] ctx_onehot(input logic [4:0] idx);
        return 32'd1 << idx;
    endfunction

endpackage

// File: rtl/ctx_prio_enc.sv
// Lowest-set-bit finder: gives the index of the lowest set bit of a 32-bit
// vector and whether any bit is set. Purely combinational.
module ctx_prio_enc (
    input  logic [31:0] vec_i,
    output logic [4:0]  idx_o,
    output logic        any_o
);

    // Scan from the top so the last hit (the lowest set bit) wins.
    always_comb begin
        idx_o = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = 5'(i);
            end
        end
    end

    assign any_o = |vec_i;

endmodule

// File: rtl/regfile_ctx_engine.sv
// Register-file context engine: SAVE streams selected registers out in
// ascending order, RESTORE writes a word stream back into the selected
// registers. Build option CTX_SKIP_R0_EN drops register 0 from every mask.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. The engine holds out_addr/out_data stable while out_valid is 1
// and out_ready is 0; it never withdraws out_valid before the transfer.
module regfile_ctx_engine
    import ctx_pkg::*;
#(
    parameter int NUM_REGS = CTX_NUM_REGS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic [31:0] cmd_mask,
    output logic [4:0]  rf_rd_addr,
    input  logic [31:0] rf_rd_data,
    output logic        rf_wr_en,
    output logic [4:0]  rf_wr_addr,
    output logic [31:0] rf_wr_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_addr,
    output logic [31:0] out_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        busy,
    output logic        done,
    output logic [1:0]  dbg_state_o
);

    // Mask bits beyond the configured register count never participate.
    localparam logic [31:0] REG_MASK = (NUM_REGS >= 32) ? 32'hFFFF_FFFF
                                                        : ((32'd1 << NUM_REGS) - 32'd1);

    ctx_state_t  state_q, state_d;
    logic [31:0] pending_q, pending_d;
    logic [31:0] mask_eff;
    logic [31:0] pending_cleared;
    logic [4:0]  idx;
    logic        any_pending;
    logic        in_save, in_restore, out_hs, in_hs;

    ctx_prio_enc u_prio (
        .vec_i (pending_q),
        .idx_o (idx),
        .any_o (any_pending)
    );

    // Stream-facing qualifiers are held low while reset is asserted so an
    // aborted RESTORE cannot issue one more write in the reset cycle.
    assign in_save    = (state_q == ST_SAVE) && !rst;
    assign in_restore = (state_q == ST_RESTORE) && !rst;

    assign out_valid  = in_save && any_pending;
    assign in_ready   = in_restore && any_pending;
    assign out_hs     = out_valid && out_ready;
    assign in_hs      = in_valid && in_ready;

    assign rf_rd_addr = in_save ? idx : 5'd0;
    assign out_addr   = in_save ? idx : 5'd0;
    assign out_data   = in_save ? rf_rd_data : 32'd0;

    assign rf_wr_en   = in_hs;
    assign rf_wr_addr = in_restore ? idx : 5'd0;
    assign rf_wr_data = in_restore ? in_data : 32'd0;

    assign cmd_ready  = (state_q == ST_IDLE) && !rst;
    assign busy       = (state_q != ST_IDLE) && !rst;
    assign done       = (state_q == ST_DONE) && !rst;
    assign dbg_state_o = state_q;

    assign pending_cleared = pending_q & ~ctx_onehot(idx);

    // Effective command mask as latched into the pending set.
    always_comb begin
        mask_eff = cmd_mask & REG_MASK;
`ifdef CTX_SKIP_R0_EN
        mask_eff[0] = 1'b0;
`else
        mask_eff = mask_eff;
`endif
    end

    // Next-state and pending-set update; one register retires per handshake.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    pending_d = mask_eff;
                    if (mask_eff == 32'd0) begin
                        state_d = ST_DONE;
                    end else if (ctx_op_t'(cmd_op) == CTX_OP_RESTORE) begin
                        state_d = ST_RESTORE;
                    end else begin
                        state_d = ST_SAVE;
                    end
                end
            end
            ST_SAVE: begin
                if (out_hs) begin
                    pending_d = pending_cleared;
                    if (pending_cleared == 32'd0) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RESTORE: begin
                if (in_hs) begin
                    pending_d = pending_cleared;
                    if (pending_cleared == 32'd0) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                pending_d = 32'd0;
            end
        endcase
    end

    // State and pending registers; synchronous reset aborts any command.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pending_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

endmodule

// File: tb/tb_regfile_ctx_engine.sv
// Directed bench for regfile_ctx_engine with a queue-based reference model
// and a per-cycle compare process.
module tb_regfile_ctx_engine;

`ifdef CTX_SKIP_R0_EN
    localparam bit SKIP_R0 = 1'b1;
`else
    localparam bit SKIP_R0 = 1'b0;
`endif

    localparam int K_IDLE = 0;
    localparam int K_SAVE = 1;
    localparam int K_REST = 2;
    localparam int K_DONE = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    logic [31:0] cmd_mask;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_rd_data;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_addr;
    logic [31:0] out_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        busy;
    logic        done;
    logic [1:0]  dbg_state;

    regfile_ctx_engine dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_mask    (cmd_mask),
        .rf_rd_addr  (rf_rd_addr),
        .rf_rd_data  (rf_rd_data),
        .rf_wr_en    (rf_wr_en),
        .rf_wr_addr  (rf_wr_addr),
        .rf_wr_data  (rf_wr_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_addr    (out_addr),
        .out_data    (out_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .busy        (busy),
        .done        (done),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- register file environment ----------------
    logic [31:0] rf [32];
    assign rf_rd_data = rf[rf_rd_addr];

    always @(negedge clk) begin
        if (rf_wr_en === 1'b1) rf[rf_wr_addr] = rf_wr_data;
    end

    // ---------------- restore-word source ----------------
    logic [31:0] drive_q[$];
    logic        hs_in;
    initial begin
        in_data = 32'hDEAD_0000;
        hs_in = 1'b0;
        forever begin
            @(negedge clk);
            hs_in = (in_valid === 1'b1) && (in_ready === 1'b1);
            @(posedge clk);
            #1;
            if (hs_in && drive_q.size() > 0) void'(drive_q.pop_front());
            in_data = (drive_q.size() > 0) ? drive_q[0] : 32'hDEAD_0000;
        end
    end

    // ---------------- scoreboard ----------------
    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Model state: what phase the engine is in and the beats/writes still owed.
    int          m_kind = K_IDLE;
    logic [36:0] exp_q[$];
    logic [31:0] rdata_q[$];
    logic [36:0] obs_q[$];
    int          done_cnt = 0;
    int          wr_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [4:0]  prev_addr;
    logic [31:0] prev_data;

    task automatic model_accept(input logic op, input logic [31:0] mask);
        logic [31:0] eff;
        logic [31:0] d;
        eff = mask;
        if (SKIP_R0) eff[0] = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (eff[i]) begin
                if (op == 1'b0) begin
                    d = rf[i];
                end else begin
                    d = (rdata_q.size() > 0) ? rdata_q.pop_front() : 32'h0;
                end
                exp_q.push_back({5'(i), d});
            end
        end
        if (eff == 32'd0) m_kind = K_DONE;
        else if (op) m_kind = K_REST;
        else m_kind = K_SAVE;
    endtask

    // Compare process: checks outputs every cycle, then advances the model.
    initial begin
        logic [36:0] e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_busy", busy, 0);
                check("rst_cmd_ready", cmd_ready, 0);
                check("rst_done", done, 0);
                check("rst_out_valid", out_valid, 0);
                check("rst_in_ready", in_ready, 0);
                check("rst_wr_en", rf_wr_en, 0);
                m_kind = K_IDLE;
                exp_q.delete();
                prev_stall = 1'b0;
            end else begin
                check("busy", busy, m_kind != K_IDLE);
                check("cmd_ready", cmd_ready, m_kind == K_IDLE);
                check("done", done, m_kind == K_DONE);
                check("out_valid", out_valid, m_kind == K_SAVE);
                check("in_ready", in_ready, m_kind == K_REST);
                check("rf_wr_en", rf_wr_en, (m_kind == K_REST) && in_valid);
                if (m_kind != K_SAVE) check("rd_addr_idle", rf_rd_addr, 0);
                if (prev_stall) begin
                    check("stall_addr", out_addr, prev_addr);
                    check("stall_data", out_data, prev_data);
                end
                if (done === 1'b1) done_cnt++;
                prev_stall = (out_valid === 1'b1) && !out_ready;
                prev_addr  = out_addr;
                prev_data  = out_data;
                case (m_kind)
                    K_IDLE: if (cmd_valid) model_accept(cmd_op, cmd_mask);
                    K_SAVE: if (out_ready) begin
                        check("save_beat_owed", exp_q.size() != 0, 1);
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            check("out_addr", out_addr, e[36:32]);
                            check("out_data", out_data, e[31:0]);
                            check("rd_addr", rf_rd_addr, e[36:32]);
                            obs_q.push_back({out_addr, out_data});
                            if (exp_q.size() == 0) m_kind = K_DONE;
                        end
                    end
                    K_REST: if (in_valid) begin
                        check("write_owed", exp_q.size() != 0, 1);
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            check("wr_addr", rf_wr_addr, e[36:32]);
                            check("wr_data", rf_wr_data, e[31:0]);
                            wr_cnt++;
                            if (exp_q.size() == 0) m_kind = K_DONE;
                        end
                    end
                    default: m_kind = K_IDLE;
                endcase
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_cmd(input logic op, input logic [31:0] mask);
        cmd_op = op;
        cmd_mask = mask;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_timeout"}, n < 200, 1);
        @(posedge clk);
        #1;
    endtask

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    int d0;
    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 1'b0;
        cmd_mask = 32'd0;
        out_ready = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_busy", busy, 0);
        @(posedge clk);
        #1;

        // SAVE of r1, r2, r4 in ascending order.
        rf[1] = 32'h11; rf[2] = 32'h22; rf[4] = 32'h44;
        obs_q.delete();
        d0 = done_cnt;
        do_cmd(1'b0, 32'h0000_0016);
        wait_idle("save3");
        check("save3_beats", obs_q.size(), 3);
        if (obs_q.size() == 3) begin
            check("save3_b0", obs_q[0], {5'd1, 32'h11});
            check("save3_b1", obs_q[1], {5'd2, 32'h22});
            check("save3_b2", obs_q[2], {5'd4, 32'h44});
        end
        check("save3_done", done_cnt - d0, 1);

        // RESTORE of r0 and r31.
        drive_q = '{32'hAAAA, 32'hBBBB};
        rdata_q = '{32'hAAAA, 32'hBBBB};
        in_valid = 1'b1;
        do_cmd(1'b1, 32'h8000_0001);
        wait_idle("rest2");
        in_valid = 1'b0;
        drive_q.delete();
        rdata_q.delete();
        if (SKIP_R0) begin
            check("rest2_r0", rf[0], 32'h1000);
            check("rest2_r31", rf[31], 32'hAAAA);
        end else begin
            check("rest2_r0", rf[0], 32'hAAAA);
            check("rest2_r31", rf[31], 32'hBBBB);
        end

        // SAVE with consumer stalled: r3 held until released.
        rf[3] = 32'h33;
        obs_q.delete();
        out_ready = 1'b0;
        do_cmd(1'b0, 32'h0000_0008);
        repeat (2) @(negedge clk);
        check("stall_lit_valid", out_valid, 1);
        check("stall_lit_addr", out_addr, 3);
        check("stall_lit_data", out_data, 32'h33);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_idle("stall");
        check("stall_beats", obs_q.size(), 1);
        if (obs_q.size() == 1) check("stall_b0", obs_q[0], {5'd3, 32'h33});

        // Empty mask: one DONE cycle, nothing else.
        obs_q.delete();
        d0 = done_cnt;
        do_cmd(1'b0, 32'd0);
        @(negedge clk);
        check("mask0_busy", busy, 1);
        check("mask0_done", done, 1);
        wait_idle("mask0");
        check("mask0_done_cnt", done_cnt - d0, 1);
        check("mask0_beats", obs_q.size(), 0);

        // RESTORE r4..r7 aborted by reset after two writes.
        drive_q = '{32'hC0, 32'hC1, 32'hC2, 32'hC3};
        rdata_q = '{32'hC0, 32'hC1, 32'hC2, 32'hC3};
        in_valid = 1'b1;
        d0 = done_cnt;
        do_cmd(1'b1, 32'h0000_00F0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        drive_q.delete();
        rdata_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check("abort_r4", rf[4], 32'hC0);
        check("abort_r5", rf[5], 32'hC1);
        check("abort_r6", rf[6], 32'h1006);
        check("abort_r7", rf[7], 32'h1007);
        check("abort_no_done", done_cnt - d0, 0);
        @(negedge clk);
        check("abort_cmd_ready", cmd_ready, 1);
        check("abort_busy", busy, 0);
        @(posedge clk);
        #1;

        // Second command offered mid-SAVE is dropped.
        rf[8] = 32'h88; rf[9] = 32'h99; rf[10] = 32'hA0;
        obs_q.delete();
        d0 = done_cnt;
        do_cmd(1'b0, 32'h0000_0700);
        cmd_op = 1'b1;
        cmd_mask = 32'h0000_FFFF;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_idle("ignore");
        repeat (3) @(posedge clk);
        #1;
        check("ignore_beats", obs_q.size(), 3);
        if (obs_q.size() == 3) begin
            check("ignore_b0", obs_q[0], {5'd8, 32'h88});
            check("ignore_b2", obs_q[2], {5'd10, 32'hA0});
        end
        check("ignore_done_cnt", done_cnt - d0, 1);
        check("ignore_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_ctx_engine.md
REGFILE_CTX_ENGINE -- requirements
Module: regfile_ctx_engine

Interface
- REQ-001: Parameter NUM_REGS, default 32, number of register-file entries addressed (5-bit address).
- REQ-002: clk  input  1  single clock; all state updates on posedge clk.
- REQ-003: rst  input  1  reset, synchronous and active-high.
- REQ-004: cmd_valid  input  1  command offered.
- REQ-005: cmd_ready  output  1  engine can accept a command.
- REQ-006: cmd_op  input  1  0 = SAVE (read regs out), 1 = RESTORE (write regs in).
- REQ-007: cmd_mask  input  32  bit i set = register i participates.
- REQ-008: rf_rd_addr  output  5  read address to register file (combinational read).
- REQ-009: rf_rd_data  input  32  read data returned same cycle.
- REQ-010: rf_wr_en, rf_wr_addr[4:0], rf_wr_data[31:0]  output  write port to register file.
- REQ-011: out_valid/out_ready (output/input, 1), out_addr (output, 5), out_data (output, 32)  saved-word stream.
- REQ-012: in_valid/in_ready (input/output, 1), in_data (input, 32)  restore-word stream.
- REQ-013: busy  output  1  engine not IDLE; done  output  1  one-cycle completion pulse.

Function
- REQ-014: FSM states IDLE, SAVE, RESTORE, DONE; cmd_ready SHALL be 1 only in IDLE.
- REQ-015: On cmd_valid&&cmd_ready, SHALL latch cmd_mask into pending and go to SAVE (op 0) or RESTORE (op 1) next cycle; if the latched mask is zero, go to DONE instead.
- REQ-016: Current index SHALL be the lowest set bit of pending; registers processed strictly in ascending order.
- REQ-017: SAVE: rf_rd_addr = index, out_valid = 1, out_addr = index, out_data = rf_rd_data; on out_valid&&out_ready clear pending[index].
- REQ-018: SAVE: out_addr/out_data SHALL remain stable while out_valid&&!out_ready.
- REQ-019: RESTORE: in_ready = 1; rf_wr_en = in_valid&&in_ready, rf_wr_addr = index, rf_wr_data = in_data; on handshake clear pending[index].
- REQ-020: rf_wr_en SHALL be 0 in every state other than RESTORE; out_valid 0 outside SAVE; in_ready 0 outside RESTORE.
- REQ-021: Throughput SHALL be one register per cycle with ready/valid held high.
- REQ-022: When the handshake clears the last pending bit, next state SHALL be DONE; DONE asserts done for exactly one cycle, then IDLE.
- REQ-023: Latency: command accept to first out_valid/in_ready = 1 cycle; last handshake to done = 1 cycle.
- REQ-024: busy = (state != IDLE); rf_rd_addr = 0 when not in SAVE.
- REQ-025: cmd_valid while busy SHALL be ignored (not queued).

Reset
- REQ-026: rst=1 at posedge clk SHALL force IDLE, pending = 0, done = 0, regardless of state, no done pulse for the aborted command.
- REQ-027: During and after reset: cmd_ready = 1 (once rst deasserted), busy = 0, out_valid = 0, in_ready = 0, rf_wr_en = 0.
- REQ-028: A RESTORE aborted mid-operation SHALL leave already-written registers as written; no further writes.

Configuration
- REQ-029: Macro CTX_SKIP_R0_EN: when defined, mask bit 0 SHALL be forced to 0 at latch (register $zero never saved or restored); when undefined, bit 0 is honoured like any other bit.

Structure
- REQ-030: Package ctx_pkg SHALL hold NUM_REGS default, ctx_op_t (SAVE/RESTORE) and ctx_state_t enum.
- REQ-031: Sub-module ctx_prio_enc: 32-bit lowest-set-bit finder, outputs 5-bit index and any-set flag, purely combinational.

Verification
- REQ-032: SAVE mask 0x0000_0016, regs 1/2/4 = 0x11/0x22/0x44, out_ready=1 -> out beats (2,0x22),(4,0x44) then (1,0x11)? No: ascending (1,0x11),(2,0x22),(4,0x44), done 1 cycle after third beat.
- REQ-033: RESTORE mask 0x8000_0001, in_data 0xAAAA, 0xBBBB -> writes r0=0xAAAA then r31=0xBBBB (with CTX_SKIP_R0_EN: only r31=0xAAAA).
- REQ-034: SAVE mask 0x0000_0008, out_ready low 5 cycles -> out_addr=3 and out_data stable throughout, single beat on release.
- REQ-035: Command with mask 0 -> busy for one cycle (DONE), done pulse, no stream activity, no writes.
- REQ-036: RESTORE mask 0x0000_00F0, rst asserted after 2 writes -> r4,r5 written, r6,r7 untouched, no done, cmd_ready=1 after reset.
- REQ-037: cmd_valid pulsed during active SAVE -> ignored; only first command's beats appear.
